ysyx_23060236_btb_update: RTL and testbench

- EXU-side writer and redirect generator for the branch target buffer (BTB).
- Accepts resolved control-flow results from EXU. Compares the actual next PC against the next PC the IFU predicted from the BTB.
- On a mispredict, raises a held redirect to the IFU.
- Queues BTB write requests in a small FIFO and drains them over the BTB write port (btb_wvalid/btb_awaddr/btb_wdata, plus btb_wready for future SRAM-based BTBs).

---
 rtl/ysyx_23060236_btb_update_pkg.sv | 13 +
 rtl/ysyx_23060236_sync_fifo.sv | 69 ++++++
 rtl/ysyx_23060236_btb_update.sv | 140 ++++++++++++++
 tb/tb_ysyx_23060236_btb_update.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060236_btb_update_pkg.sv
// Shared definitions for the BTB update path: the address-width default, the
// FSM state encoding and the sequential PC increment.
package ysyx_23060236_btb_update_pkg;

   localparam int ADDR_LEN_DEFAULT = 32;
   localparam int PC_INC           = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      REDIR = 1'b1
   } btb_upd_state_e;

endpackage

// File: rtl/ysyx_23060236_sync_fifo.sv
// Parameterised synchronous valid/ready FIFO with full/empty flags.
// DEPTH must be a power of two (>= 2); pointers carry one extra wrap bit.
module ysyx_23060236_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_valid_i,
   output logic             push_ready_o,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             pop_valid_o,
   input  logic             pop_ready_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push;
   logic             pop;

   // Same index with differing wrap bits means the writer has lapped the reader.
   assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o      = (wr_ptr_q == rd_ptr_q);
   assign push_ready_o = !full_o;
   assign pop_valid_o  = !empty_o;
   assign pop_data_o   = mem_q[rd_ptr_q[AW-1:0]];

   assign push = push_valid_i & push_ready_o;
   assign pop  = pop_valid_o & pop_ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/ysyx_23060236_btb_update.sv
// EXU-side BTB writer: detects mispredicts, holds an IFU redirect and queues
// BTB writes. Define YSYX_23060236_BTB_PERF_EN to build the perf counters.
module ysyx_23060236_btb_update
   import ysyx_23060236_btb_update_pkg::*;
#(
   parameter int ADDR_LEN   = ADDR_LEN_DEFAULT,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_LEN    = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                res_valid,
   output logic                res_ready,
   input  logic [ADDR_LEN-1:0] res_pc,
   input  logic [ADDR_LEN-1:0] res_pred_npc,
   input  logic                res_is_cf,
   input  logic                res_taken,
   input  logic [ADDR_LEN-1:0] res_target,
   output logic                redirect_valid,
   input  logic                redirect_ready,
   output logic [ADDR_LEN-1:0] redirect_pc,
   output logic                btb_wvalid,
   input  logic                btb_wready,
   output logic [ADDR_LEN-1:0] btb_awaddr,
   output logic [ADDR_LEN-1:0] btb_wdata,
   output logic [CNT_LEN-1:0]  perf_cf_cnt,
   output logic [CNT_LEN-1:0]  perf_mp_cnt
);

   btb_upd_state_e         state_q, state_d;
   logic [ADDR_LEN-1:0]    redirect_pc_q, redirect_pc_d;
   logic [ADDR_LEN-1:0]    actual_npc;
   logic                   mispredict;
   logic                   need_upd;
   logic                   fire;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_push_ready;
   logic                   fifo_pop_valid;
   logic                   fifo_unused;
   logic [2*ADDR_LEN-1:0]  fifo_head;

   assign actual_npc = res_taken ? res_target : (res_pc + ADDR_LEN'(PC_INC));
   assign mispredict = res_is_cf & (actual_npc != res_pred_npc);
   assign need_upd   = res_is_cf & res_taken & (res_target != res_pred_npc);

   // Acceptance depends only on registered state so it never combinationally
   // follows res_valid; a pop in the same cycle does not open a slot.
   assign res_ready = (state_q == IDLE) & !fifo_full;
   assign fire      = res_valid & res_ready;

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         IDLE: begin
            if (fire && mispredict) begin
               state_d       = REDIR;
               redirect_pc_d = actual_npc;
            end
         end
         REDIR: begin
            if (redirect_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign redirect_valid = (state_q == REDIR);
   assign redirect_pc    = redirect_pc_q;

   ysyx_23060236_sync_fifo #(
      .WIDTH (2*ADDR_LEN),
      .DEPTH (FIFO_DEPTH)
   ) u_upd_fifo (
      .clock        (clock),
      .reset        (reset),
      .push_valid_i (fire & need_upd),
      .push_ready_o (fifo_push_ready),
      .push_data_i  ({res_pc, res_target}),
      .pop_valid_o  (fifo_pop_valid),
      .pop_ready_i  (btb_wready),
      .pop_data_o   (fifo_head),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   // Handshake mirrors of full/empty; the flags themselves drive the logic.
   assign fifo_unused = fifo_push_ready ^ fifo_pop_valid;

   assign btb_wvalid = !fifo_empty;
   assign btb_awaddr = fifo_head[2*ADDR_LEN-1:ADDR_LEN];
   assign btb_wdata  = fifo_head[ADDR_LEN-1:0];

`ifdef YSYX_23060236_BTB_PERF_EN
   logic [CNT_LEN-1:0] cf_cnt_q, cf_cnt_d;
   logic [CNT_LEN-1:0] mp_cnt_q, mp_cnt_d;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      cf_cnt_d = cf_cnt_q;
      mp_cnt_d = mp_cnt_q;
      if (fire && res_is_cf && (cf_cnt_q != '1)) begin
         cf_cnt_d = cf_cnt_q + CNT_LEN'(1);
      end
      if (fire && mispredict && (mp_cnt_q != '1)) begin
         mp_cnt_d = mp_cnt_q + CNT_LEN'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cf_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else begin
         cf_cnt_q <= cf_cnt_d;
         mp_cnt_q <= mp_cnt_d;
      end
   end

   assign perf_cf_cnt = cf_cnt_q;
   assign perf_mp_cnt = mp_cnt_q;
`else
   assign perf_cf_cnt = '0;
   assign perf_mp_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060236_btb_update.sv
// Directed bench for ysyx_23060236_btb_update: single-fire vector table plus
// hand-written redirect-stall, FIFO backpressure and async-reset sequences.
module tb_ysyx_23060236_btb_update;

`ifdef YSYX_23060236_BTB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] predNpc;
      logic        isCf;
      logic        taken;
      logic [31:0] target;
      logic        expRedir;
      logic [31:0] expRedirPc;
      logic        expWr;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        resValid;
   logic        resReady;
   logic [31:0] resPc;
   logic [31:0] resPredNpc;
   logic        resIsCf;
   logic        resTaken;
   logic [31:0] resTarget;
   logic        redirectValid;
   logic        redirectReady;
   logic [31:0] redirectPc;
   logic        btbWvalid;
   logic        btbWready;
   logic [31:0] btbAwaddr;
   logic [31:0] btbWdata;
   logic [31:0] perfCfCnt;
   logic [31:0] perfMpCnt;

   int testCount = 0;
   int failCount = 0;
   int expCf     = 0;
   int expMp     = 0;

   vec_t vecs [7];

   ysyx_23060236_btb_update dut (
      .clock          (clock),
      .reset          (reset),
      .res_valid      (resValid),
      .res_ready      (resReady),
      .res_pc         (resPc),
      .res_pred_npc   (resPredNpc),
      .res_is_cf      (resIsCf),
      .res_taken      (resTaken),
      .res_target     (resTarget),
      .redirect_valid (redirectValid),
      .redirect_ready (redirectReady),
      .redirect_pc    (redirectPc),
      .btb_wvalid     (btbWvalid),
      .btb_wready     (btbWready),
      .btb_awaddr     (btbAwaddr),
      .btb_wdata      (btbWdata),
      .perf_cf_cnt    (perfCfCnt),
      .perf_mp_cnt    (perfMpCnt)
   );

   always #5 clock = ~clock;

   function automatic vec_t mkVec(input logic [31:0] pc, input logic [31:0] predNpc,
                                  input logic isCf, input logic taken,
                                  input logic [31:0] target, input logic expRedir,
                                  input logic [31:0] expRedirPc, input logic expWr);
      vec_t v;
      v.pc = pc; v.predNpc = predNpc; v.isCf = isCf; v.taken = taken;
      v.target = target; v.expRedir = expRedir; v.expRedirPc = expRedirPc;
      v.expWr = expWr;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   task automatic checkPerf(input string tag);
      checkOutput({tag, "_perf_cf"}, perfCfCnt, PERF ? 32'(expCf) : 32'd0);
      checkOutput({tag, "_perf_mp"}, perfMpCnt, PERF ? 32'(expMp) : 32'd0);
   endtask

   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] predNpc,
                                input logic isCf, input logic taken,
                                input logic [31:0] target);
      resPc      = pc;
      resPredNpc = predNpc;
      resIsCf    = isCf;
      resTaken   = taken;
      resTarget  = target;
      resValid   = 1'b1;
   endtask

   initial begin
      vecs[0] = mkVec(32'h8000_0000, 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0,          1'b0);
      vecs[1] = mkVec(32'h8000_0020, 32'h8000_0080, 1'b1, 1'b0, 32'h8000_0080, 1'b1, 32'h8000_0024, 1'b0);
      vecs[2] = mkVec(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 32'h0,          1'b0);
      vecs[3] = mkVec(32'h8000_0040, 32'h1111_0000, 1'b0, 1'b1, 32'h2222_0000, 1'b0, 32'h0,          1'b0);
      vecs[4] = mkVec(32'h8000_0050, 32'h8000_0054, 1'b1, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0300, 1'b1);
      vecs[5] = mkVec(32'h8000_0060, 32'h8000_0064, 1'b1, 1'b0, 32'h8000_0500, 1'b0, 32'h0,          1'b0);
      vecs[6] = mkVec(32'h8000_0080, 32'h8000_0400, 1'b1, 1'b0, 32'h8000_0400, 1'b1, 32'h8000_0084, 1'b0);

      reset         = 1'b0;
      resValid      = 1'b0;
      resPc         = '0;
      resPredNpc    = '0;
      resIsCf       = 1'b0;
      resTaken      = 1'b0;
      resTarget     = '0;
      redirectReady = 1'b0;
      btbWready     = 1'b0;

      #12;
      checkBit("rst_redirect_valid", redirectValid, 1'b0);
      checkOutput("rst_redirect_pc", redirectPc, 32'h0);
      checkBit("rst_btb_wvalid", btbWvalid, 1'b0);
      checkPerf("rst");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkBit("rst_res_ready", resReady, 1'b1);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].pc, vecs[i].predNpc, vecs[i].isCf, vecs[i].taken, vecs[i].target);
         checkBit($sformatf("v%0d_res_ready_pre", i), resReady, 1'b1);
         @(negedge clock);
         resValid = 1'b0;
         if (vecs[i].isCf) expCf++;
         if (vecs[i].expRedir) expMp++;
         checkBit($sformatf("v%0d_redirect_valid", i), redirectValid, vecs[i].expRedir);
         if (vecs[i].expRedir)
            checkOutput($sformatf("v%0d_redirect_pc", i), redirectPc, vecs[i].expRedirPc);
         checkBit($sformatf("v%0d_btb_wvalid", i), btbWvalid, vecs[i].expWr);
         if (vecs[i].expWr) begin
            checkOutput($sformatf("v%0d_btb_awaddr", i), btbAwaddr, vecs[i].pc);
            checkOutput($sformatf("v%0d_btb_wdata", i), btbWdata, vecs[i].target);
         end
         checkPerf($sformatf("v%0d", i));
         redirectReady = 1'b1;
         btbWready     = 1'b1;
         @(negedge clock);
         redirectReady = 1'b0;
         btbWready     = 1'b0;
         checkBit($sformatf("v%0d_clean_redirect", i), redirectValid, 1'b0);
         checkBit($sformatf("v%0d_clean_wvalid", i), btbWvalid, 1'b0);
         checkBit($sformatf("v%0d_clean_ready", i), resReady, 1'b1);
      end

      // Taken miss while the IFU stalls the redirect for three cycles.
      applyStimulus(32'h8000_0010, 32'h8000_0014, 1'b1, 1'b1, 32'h8000_0200);
      checkBit("stall_res_ready_pre", resReady, 1'b1);
      @(negedge clock);
      resValid = 1'b0;
      expCf++;
      expMp++;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) redirectReady = 1'b1;
         checkBit($sformatf("stall%0d_redirect_valid", k), redirectValid, 1'b1);
         checkOutput($sformatf("stall%0d_redirect_pc", k), redirectPc, 32'h8000_0200);
         checkBit($sformatf("stall%0d_res_ready", k), resReady, 1'b0);
         checkBit($sformatf("stall%0d_btb_wvalid", k), btbWvalid, 1'b1);
         checkOutput($sformatf("stall%0d_btb_awaddr", k), btbAwaddr, 32'h8000_0010);
         checkOutput($sformatf("stall%0d_btb_wdata", k), btbWdata, 32'h8000_0200);
         @(negedge clock);
      end
      redirectReady = 1'b0;
      checkBit("stall_done_redirect", redirectValid, 1'b0);
      checkBit("stall_done_ready", resReady, 1'b1);
      checkBit("stall_done_wvalid", btbWvalid, 1'b1);
      checkPerf("stall");
      btbWready = 1'b1;
      @(negedge clock);
      btbWready = 1'b0;
      checkBit("stall_drained", btbWvalid, 1'b0);

      // Two queued updates fill the FIFO while the BTB refuses writes.
      redirectReady = 1'b1;
      applyStimulus(32'h8000_0100, 32'h8000_0104, 1'b1, 1'b1, 32'h8000_0800);
      checkBit("bp1_res_ready_pre", resReady, 1'b1);
      @(negedge clock);
      resValid = 1'b0;
      checkBit("bp1_redirect_valid", redirectValid, 1'b1);
      checkOutput("bp1_redirect_pc", redirectPc, 32'h8000_0800);
      @(negedge clock);
      checkBit("bp2_res_ready_pre", resReady, 1'b1);
      applyStimulus(32'h8000_0110, 32'h8000_0114, 1'b1, 1'b1, 32'h8000_0900);
      @(negedge clock);
      resValid = 1'b0;
      checkBit("bp2_res_ready_redir", resReady, 1'b0);
      @(negedge clock);
      checkBit("bp_full_redirect", redirectValid, 1'b0);
      checkBit("bp_full_res_ready", resReady, 1'b0);
      checkBit("bp_full_wvalid", btbWvalid, 1'b1);
      checkOutput("bp_head0_awaddr", btbAwaddr, 32'h8000_0100);
      checkOutput("bp_head0_wdata", btbWdata, 32'h8000_0800);
      btbWready = 1'b1;
      @(negedge clock);
      checkBit("bp_head1_wvalid", btbWvalid, 1'b1);
      checkOutput("bp_head1_awaddr", btbAwaddr, 32'h8000_0110);
      checkOutput("bp_head1_wdata", btbWdata, 32'h8000_0900);
      checkBit("bp_head1_res_ready", resReady, 1'b1);
      @(negedge clock);
      btbWready     = 1'b0;
      redirectReady = 1'b0;
      checkBit("bp_empty_wvalid", btbWvalid, 1'b0);
      checkBit("bp_empty_res_ready", resReady, 1'b1);
      expCf += 2;
      expMp += 2;
      checkPerf("bp");

      // Asynchronous reset while redirecting with one write queued.
      applyStimulus(32'h8000_0200, 32'h8000_0204, 1'b1, 1'b1, 32'h8000_0A00);
      @(negedge clock);
      resValid = 1'b0;
      checkBit("ar_pre_redirect", redirectValid, 1'b1);
      checkBit("ar_pre_wvalid", btbWvalid, 1'b1);
      #2;
      reset = 1'b0;
      expCf = 0;
      expMp = 0;
      #1;
      checkBit("ar_redirect_valid", redirectValid, 1'b0);
      checkBit("ar_btb_wvalid", btbWvalid, 1'b0);
      checkOutput("ar_redirect_pc", redirectPc, 32'h0);
      checkPerf("ar");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkBit("ar_post_res_ready", resReady, 1'b1);
      checkBit("ar_post_redirect", redirectValid, 1'b0);
      checkBit("ar_post_wvalid", btbWvalid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
